// File: rtl/elastic_shift_pipeline_stage.sv
// ----------------------------------------------------------------------------
// elastic_stage
//   One storage stage of the elastic shift pipeline: a valid flag plus a data
//   word. The parent decides when the stage may load (it is empty or its
//   contents are moving on this cycle) and what it loads from.
//
// Ports
//   clk      sole clock, all state on posedge
//   rst      synchronous active-high reset (clears the valid flag only)
//   i_flush  synchronous discard of the stored transfer
//   i_load   stage is empty or advancing, so it takes its predecessor's value
//   i_vld    predecessor offers a valid transfer this cycle
//   i_data   predecessor payload
//   o_vld    stage holds a valid transfer
//   o_data   stored payload (meaningless while o_vld = 0)
// ----------------------------------------------------------------------------
module elastic_stage #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_vld,
    input  logic [width-1:0] i_data,
    output logic             o_vld,
    output logic [width-1:0] o_data
);

    logic             r_vld;
    logic [width-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            // An advancing stage with nothing behind it becomes empty here.
            r_vld <= i_vld;
        end
    end

    // Data words are not reset; they only change when a valid word arrives.
    always_ff @(posedge clk) begin
        if (i_load && i_vld) begin
            r_data <= i_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/elastic_shift_pipeline.sv
// ----------------------------------------------------------------------------
// elastic_shift_pipeline
//   depth-stage valid/ready shift pipeline with bubble collapse. With the
//   output always ready it behaves like a plain depth-stage shift register;
//   under backpressure every valid stage holds while empty stages ahead of
//   the stall keep filling, so all depth entries are usable as storage.
//
// Parameters
//   width    data bits per transfer
//   depth    number of storage stages (>= 1)
//
// Ports
//   clk      sole clock, all state on posedge
//   rst      synchronous active-high reset (valid flags and count only)
//   flush    synchronous discard of all stored transfers
//   in_vld   upstream transfer offered
//   in_rdy   transfer accepted this cycle (combinational on out_rdy)
//   in_data  upstream payload
//   out_vld  last stage holds a valid transfer (direct from flop)
//   out_rdy  downstream accepts this cycle
//   out_data last-stage payload (direct from flop)
//   count    number of valid stages
// ----------------------------------------------------------------------------
module elastic_shift_pipeline #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [width-1:0]           in_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [width-1:0]           out_data,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(depth + 1);

    logic [depth-1:0] w_vld;
    logic [width-1:0] w_data [depth];
    logic [depth-1:0] w_adv;
    // w_space[i]: stage i is empty or advancing, i.e. it may load this cycle.
    // w_space[depth] stands for the downstream consumer.
    logic [depth:0]   w_space;
    logic             w_accept;
    logic             w_emit;
    logic [CNT_W-1:0] r_count;

    // Ready ripples backwards from the output: a stage advances when it is
    // valid and its successor has space; it has space itself when it is
    // empty or advancing.
    always_comb begin
        w_space        = '0;
        w_adv          = '0;
        w_space[depth] = out_rdy;
        for (int unsigned i = depth; i > 0; i--) begin
            w_adv[i-1]   = w_vld[i-1] & w_space[i];
            w_space[i-1] = ~w_vld[i-1] | w_space[i];
        end
    end

    assign in_rdy   = w_space[0] & ~flush;
    assign w_accept = in_vld & in_rdy;
    assign w_emit   = w_adv[depth-1];

    for (genvar g = 0; g < depth; g++) begin : g_stage
        logic             w_src_vld;
        logic [width-1:0] w_src_data;

        if (g == 0) begin : g_head
            assign w_src_vld  = w_accept;
            assign w_src_data = in_data;
        end else begin : g_body
            assign w_src_vld  = w_adv[g-1];
            assign w_src_data = w_data[g-1];
        end

        elastic_stage #(
            .width(width)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_flush(flush),
            .i_load (w_space[g]),
            .i_vld  (w_src_vld),
            .i_data (w_src_data),
            .o_vld  (w_vld[g]),
            .o_data (w_data[g])
        );
    end

    // Accept and emit may happen on the same edge; the add/subtract nets out.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_emit);
        end
    end

    assign out_vld  = w_vld[depth-1];
    assign out_data = w_data[depth-1];
    assign count    = r_count;

endmodule

// File: tb/tb_elastic_shift_pipeline.sv
module tb_elastic_shift_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;

    logic       in_vld4, in_rdy4, out_vld4, out_rdy4;
    logic [7:0] in_data4, out_data4;
    logic [2:0] count4;

    logic       in_vld1, in_rdy1, out_vld1, out_rdy1;
    logic [7:0] in_data1, out_data1;
    logic [0:0] count1;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    logic [7:0] q4[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    elastic_shift_pipeline #(.width(8), .depth(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld4), .in_rdy(in_rdy4), .in_data(in_data4),
        .out_vld(out_vld4), .out_rdy(out_rdy4), .out_data(out_data4),
        .count(count4)
    );

    elastic_shift_pipeline #(.width(8), .depth(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1),
        .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1),
        .count(count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: the signals seen at the negedge are what the next posedge
    // will sample, so each negedge decides the transfers of the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q4.delete();
            end else begin
                check("count4", 32'(count4), q4.size());
                check("in_rdy4", 32'(in_rdy4), 32'(((q4.size() < 4) || out_rdy4) && !flush));
                if (flush) begin
                    q4.delete();
                end else begin
                    if (out_vld4 && out_rdy4) begin
                        if (q4.size() == 0) check("emit4_unexpected", 32'(out_vld4), 0);
                        else check("data4", 32'(out_data4), 32'(q4.pop_front()));
                    end
                    if (in_vld4 && in_rdy4) q4.push_back(in_data4);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q1.delete();
            end else begin
                check("count1", 32'(count1), q1.size());
                check("in_rdy1", 32'(in_rdy1), 32'(((q1.size() < 1) || out_rdy1) && !flush));
                if (flush) begin
                    q1.delete();
                end else begin
                    if (out_vld1 && out_rdy1) begin
                        if (q1.size() == 0) check("emit1_unexpected", 32'(out_vld1), 0);
                        else check("data1", 32'(out_data1), 32'(q1.pop_front()));
                    end
                    if (in_vld1 && in_rdy1) q1.push_back(in_data1);
                end
            end
        end
    end

    typedef struct {
        logic       in_vld;
        logic       out_rdy;
        logic [7:0] in_data;
        logic       e_in_rdy;
        logic       e_out_vld;
        logic [7:0] e_out_data;
        logic [2:0] e_count;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Backpressure: fill while stalled, then release.
        tbl[0]  = '{1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 8'h00, 3'd1};
        tbl[2]  = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b0, 8'h00, 3'd2};
        tbl[3]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 8'h00, 3'd3};
        tbl[4]  = '{1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 8'hA0, 3'd4};
        tbl[5]  = '{1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 8'hA0, 3'd4};
        tbl[6]  = '{1'b1, 1'b1, 8'hA4, 1'b1, 1'b1, 8'hA0, 3'd4};
        tbl[7]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA1, 3'd4};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA2, 3'd4};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA3, 3'd3};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA4, 3'd2};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 3'd1};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0};

        rst = 1'b1; flush = 1'b0;
        in_vld4 = 1'b0; out_rdy4 = 1'b0; in_data4 = '0;
        in_vld1 = 1'b0; out_rdy1 = 1'b0; in_data1 = '0;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_vld4", 32'(out_vld4), 0);
        check("rst_count4", 32'(count4), 0);
        check("rst_in_rdy4", 32'(in_rdy4), 1);
        check("rst_out_vld1", 32'(out_vld1), 0);
        check("rst_in_rdy1", 32'(in_rdy1), 1);
        tick();

        // Streaming 0x01..0x10 with out_rdy held high
        for (int k = 0; k <= 20; k++) begin
            in_vld4 = (k < 16);
            in_data4 = 8'(k + 1);
            out_rdy4 = 1'b1;
            @(negedge clk);
            check("strm_in_rdy", 32'(in_rdy4), 1);
            if (k >= 4 && k < 20) begin
                check("strm_out_vld", 32'(out_vld4), 1);
                check("strm_out_data", 32'(out_data4), 32'(k - 3));
            end else begin
                check("strm_out_vld_idle", 32'(out_vld4), 0);
            end
            if (k >= 4 && k <= 16) check("strm_count", 32'(count4), 4);
            tick();
        end
        in_vld4 = 1'b0;

        // Table-driven backpressure sequence
        for (int unsigned i = 0; i < 13; i++) begin
            in_vld4 = tbl[i].in_vld;
            out_rdy4 = tbl[i].out_rdy;
            in_data4 = tbl[i].in_data;
            @(negedge clk);
            check($sformatf("bp%0d_in_rdy", i), 32'(in_rdy4), 32'(tbl[i].e_in_rdy));
            check($sformatf("bp%0d_out_vld", i), 32'(out_vld4), 32'(tbl[i].e_out_vld));
            check($sformatf("bp%0d_count", i), 32'(count4), 32'(tbl[i].e_count));
            if (tbl[i].e_out_vld)
                check($sformatf("bp%0d_out_data", i), 32'(out_data4), 32'(tbl[i].e_out_data));
            tick();
        end
        in_vld4 = 1'b0;

        // Bubble collapse: 0x11, two idle cycles, 0x22, all while stalled
        out_rdy4 = 1'b0;
        in_vld4 = 1'b1; in_data4 = 8'h11;
        tick();
        in_vld4 = 1'b0;
        repeat (2) tick();
        in_vld4 = 1'b1; in_data4 = 8'h22;
        @(negedge clk);
        check("bub_in_rdy", 32'(in_rdy4), 1);
        tick();
        in_vld4 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("bub_count", 32'(count4), 2);
        check("bub_hold_vld", 32'(out_vld4), 1);
        check("bub_hold_data", 32'(out_data4), 32'h11);
        tick();
        out_rdy4 = 1'b1;
        @(negedge clk);
        check("bub_first", 32'(out_data4), 32'h11);
        tick();
        @(negedge clk);
        check("bub_second_vld", 32'(out_vld4), 1);
        check("bub_second", 32'(out_data4), 32'h22);
        tick();
        @(negedge clk);
        check("bub_empty_vld", 32'(out_vld4), 0);
        check("bub_empty_count", 32'(count4), 0);
        tick();

        // Flush with count = 3 and the output holding a valid word
        out_rdy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vld4 = 1'b1; in_data4 = 8'(8'hC0 + i);
            tick();
        end
        in_vld4 = 1'b0;
        tick();
        flush = 1'b1; in_vld4 = 1'b1; in_data4 = 8'hEE; out_rdy4 = 1'b1;
        @(negedge clk);
        check("fl_count_before", 32'(count4), 3);
        check("fl_out_vld_before", 32'(out_vld4), 1);
        check("fl_in_rdy", 32'(in_rdy4), 0);
        tick();
        flush = 1'b0; in_vld4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fl_out_vld_after", 32'(out_vld4), 0);
            check("fl_count_after", 32'(count4), 0);
            tick();
        end

        // Mid-stream reset with the pipeline full
        out_rdy4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_vld4 = 1'b1; in_data4 = 8'(8'hD0 + i);
            tick();
        end
        in_vld4 = 1'b0;
        @(negedge clk);
        check("mr_count_full", 32'(count4), 4);
        tick();
        rst = 1'b1; in_vld4 = 1'b1; in_data4 = 8'h99; out_rdy4 = 1'b1;
        tick();
        rst = 1'b0; in_vld4 = 1'b0;
        @(negedge clk);
        check("mr_out_vld", 32'(out_vld4), 0);
        check("mr_count", 32'(count4), 0);
        check("mr_in_rdy", 32'(in_rdy4), 1);
        in_vld4 = 1'b1; in_data4 = 8'h55;
        tick();
        in_vld4 = 1'b0;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            check("mr_lat_vld", 32'(out_vld4), 0);
            tick();
        end
        @(negedge clk);
        check("mr_55_vld", 32'(out_vld4), 1);
        check("mr_55_data", 32'(out_data4), 32'h55);
        tick();

        // Random traffic on both depths against the queue scoreboards
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_vld4  = 1'($urandom_range(0, 1));
            in_data4 = 8'($urandom);
            out_rdy4 = ($urandom_range(0, 3) != 0) ^ (cyc[10] & 1'($urandom_range(0, 1)));
            in_vld1  = 1'($urandom_range(0, 1));
            in_data1 = 8'($urandom);
            out_rdy1 = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 255) == 0);
            tick();
        end
        flush = 1'b0;
        in_vld4 = 1'b0; out_rdy4 = 1'b1;
        in_vld1 = 1'b0; out_rdy1 = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("drain4", q4.size(), 0);
        check("drain1", q1.size(), 0);
        check("drain_vld4", 32'(out_vld4), 0);
        check("drain_vld1", 32'(out_vld1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elastic_shift_pipeline.md
ELASTIC_SHIFT_PIPELINE -- requirements
Module: elastic_shift_pipeline

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning data bits per transfer.
REQ-002 The block SHALL have parameter depth, default 8, meaning number of storage stages; legal range depth >= 1.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port flush  input  1  synchronous discard of all stored transfers.
REQ-006 The block SHALL have port in_vld  input  1  upstream transfer offered.
REQ-007 The block SHALL have port in_rdy  output  1  block accepts the offered transfer this cycle.
REQ-008 The block SHALL have port in_data  input  width  upstream payload.
REQ-009 The block SHALL have port out_vld  output  1  last stage holds a valid transfer.
REQ-010 The block SHALL have port out_rdy  input  1  downstream accepts this cycle.
REQ-011 The block SHALL have port out_data  output  width  last-stage payload; value unspecified while out_vld = 0.
REQ-012 The block SHALL have port count  output  $clog2(depth+1)  number of valid stages.

Function
REQ-013 Transfers SHALL occur on a posedge where vld and rdy are both high on the same side (in_vld & in_rdy, out_vld & out_rdy).
REQ-014 Each stage i SHALL hold one vld bit and one width-bit data word; out_vld/out_data SHALL be driven by stage depth-1 directly from flops.
REQ-015 Stage depth-1 SHALL advance when out_rdy = 1; stage i < depth-1 SHALL advance when vld[i] = 1 and stage i+1 is empty or advancing (bubble collapse).
REQ-016 A stage SHALL load from its predecessor (stage 0 from in_data) when it is empty or advancing, and become empty when it advances with no incoming valid.
REQ-017 in_rdy SHALL equal (stage 0 empty or advancing) and not flush; in_rdy MAY depend combinationally on out_rdy.
REQ-018 With out_rdy held 1, a transfer accepted at edge N SHALL be presented on out_vld/out_data after edge N+depth-1 (visible during cycle N+depth), matching a plain depth-stage shift register.
REQ-019 Throughput SHALL be one transfer per cycle with no bubbles when in_vld and out_rdy are continuously 1.
REQ-020 Transfer order SHALL be preserved; no transfer SHALL be duplicated or dropped except by flush or rst.
REQ-021 When full (count = depth) and out_rdy = 1, the block SHALL accept a new input in the same cycle (in_rdy = 1).
REQ-022 When out_rdy = 0, data in every valid stage SHALL hold unchanged; empty stages ahead of the stall SHALL still fill.
REQ-023 flush = 1 SHALL clear all vld bits at that edge, ignore in_data, and not count as an output transfer even if out_rdy = 1.
REQ-024 count SHALL be registered or derived from vld bits and always equal the number of set vld bits; increments/decrements SHALL net correctly on simultaneous accept and emit.
REQ-025 depth = 1 SHALL behave as a single-entry registered buffer with in_rdy = !vld[0] | out_rdy.

Reset
REQ-026 On rst = 1 at an edge, all vld bits SHALL clear: out_vld = 0, count = 0, in_rdy = 1 from the following cycle.
REQ-027 rst SHALL take priority over flush and all handshakes; data words SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL discard all stored transfers with no output transfer at that edge.

Structure
REQ-029 No shared package SHALL be required; count width SHALL be a localparam inside the module.
REQ-030 One sub-module elastic_stage (vld + data flop, load/advance control) SHALL be instantiated depth times via generate.

Verification (width = 8, depth = 4)
REQ-031 Streaming: in_vld = 1 with data 0x01..0x10, out_rdy = 1 -> 0x01 appears on cycle 4 after first accept, then one word per cycle, in order, count steady at 4.
REQ-032 Backpressure: load 0xA0..0xA5 with out_rdy = 0 -> in_rdy drops after 4 accepts, count = 4, out_data = 0xA0 held; release out_rdy -> 0xA0..0xA3 out in order, 0xA4 accepted the same cycle the first emit occurs.
REQ-033 Bubble collapse: send 0x11, idle 2 cycles, send 0x22 with out_rdy = 0 -> both stored, count = 2; release -> 0x11 then 0x22 on consecutive cycles.
REQ-034 Flush: count = 3, assert flush with in_vld = 1, out_rdy = 1 -> next cycle count = 0, out_vld = 0, nothing emitted, offered word not accepted.
REQ-035 Mid-stream reset: count = 4, rst for 1 cycle -> out_vld = 0, count = 0, in_rdy = 1; subsequent 0x55 emerges after 4 cycles.
REQ-036 Random: random in_vld/out_rdy for 10000 cycles against a queue model -> zero ordering, loss or count mismatches, depth = 1 and depth = 4 both run.
